// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag bit positions.
// Pure declarations, no logic.
// Imported by alu_seq and alu_muldiv_iter.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL1 = 4'h4;
  localparam logic [3:0] OP_SHR1 = 4'h5;
  localparam logic [3:0] OP_ROL1 = 4'h6;
  localparam logic [3:0] OP_ROR1 = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Flag vector layout {C, Z, N, V}
  localparam int F_C = 3;
  localparam int F_Z = 2;
  localparam int F_N = 1;
  localparam int F_V = 0;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add, lsb-first) / restoring divide (msb-first).
// WIDTH steps after start; lo/hi show the post-step value, final result when done pulses.
// No backpressure: the parent drives step only while it is waiting for this unit.
module alu_muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             done
);

  // hi = partial product high half / remainder, lo = multiplier / quotient
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q;
  logic             is_div_q;
  // One-hot marker walking toward bit 0 flags the last iteration
  logic [WIDTH-1:0] mark_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // One iteration of either algorithm, selected by the captured opcode
  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : '0)};
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};
    hi_d    = sum[WIDTH:1];
    lo_d    = {sum[0], lo_q[WIDTH-1:1]};
    if (is_div_q) begin
      // Remainder stays below the divisor, so diff[WIDTH] is a clean borrow
      if (!diff[WIDTH]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign lo   = lo_d;
  assign hi   = hi_d;
  assign done = step && mark_q[0];

  // Operand capture on start, state advance on each step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      mark_q   <= '0;
    end else if (start) begin
      hi_q     <= '0;
      lo_q     <= a;
      opb_q    <= b;
      is_div_q <= is_div;
      mark_q   <= {1'b1, {(WIDTH-1){1'b0}}};
    end else if (step) begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      mark_q <= mark_q >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and {C,Z,N,V} flags; one op in flight.
// Latency: 1 cycle for single-cycle ops and DIV-by-zero, WIDTH+1 cycles for MUL/DIV.
// Result held while out_ready=0; in_ready follows out_ready in DONE for back-to-back ops.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] alu_out_q;
  logic [3:0]       flags_q;

  logic             accept;
  logic             is_iter;
  logic [WIDTH:0]   add_w;
  logic [WIDTH-1:0] res_sc;
  logic             c_sc, v_sc;
  logic [3:0]       flags_sc, flags_it;
  logic [WIDTH-1:0] it_lo, it_hi;
  logic             it_done;

  assign accept  = in_valid && in_ready;
  // DIV by zero bypasses the iterator and completes like a single-cycle op
  assign is_iter = (alu_sel == OP_MUL) || ((alu_sel == OP_DIV) && (b != '0));

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && is_iter),
    .is_div (alu_sel == OP_DIV),
    .a      (a),
    .b      (b),
    .step   (state_q == ST_BUSY),
    .lo     (it_lo),
    .hi     (it_hi),
    .done   (it_done)
  );

  // Single-cycle result and flags, computed straight from the live operands
  always_comb begin
    add_w  = {1'b0, a} + {1'b0, b};
    res_sc = '0;
    c_sc   = 1'b0;
    v_sc   = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        res_sc = add_w[WIDTH-1:0];
        c_sc   = add_w[WIDTH];
        v_sc   = (a[WIDTH-1] == b[WIDTH-1]) && (res_sc[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_sc = a - b;
        c_sc   = a < b;
        v_sc   = (a[WIDTH-1] != b[WIDTH-1]) && (res_sc[WIDTH-1] != a[WIDTH-1]);
      end
      OP_DIV: begin
        res_sc = '1;
        v_sc   = 1'b1;
      end
      OP_SHL1: begin
        res_sc = {a[WIDTH-2:0], 1'b0};
        c_sc   = a[WIDTH-1];
      end
      OP_SHR1: begin
        res_sc = {1'b0, a[WIDTH-1:1]};
        c_sc   = a[0];
      end
      OP_ROL1: res_sc = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR1: res_sc = {a[0], a[WIDTH-1:1]};
      OP_AND:  res_sc = a & b;
      OP_OR:   res_sc = a | b;
      OP_XOR:  res_sc = a ^ b;
      OP_NOR:  res_sc = ~(a | b);
      OP_NAND: res_sc = ~(a & b);
      OP_XNOR: res_sc = ~(a ^ b);
      OP_GT:   res_sc = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_EQ:   res_sc = {{(WIDTH-1){1'b0}}, (a == b)};
      default: res_sc = '0;
    endcase
    flags_sc       = '0;
    flags_sc[F_C]  = c_sc;
    flags_sc[F_Z]  = (res_sc == '0);
    flags_sc[F_N]  = res_sc[WIDTH-1];
    flags_sc[F_V]  = v_sc;
  end

  // Flags for the iterative result; only MUL reports a carry (high half non-zero)
  always_comb begin
    flags_it      = '0;
    flags_it[F_C] = (op_q == OP_MUL) && (it_hi != '0);
    flags_it[F_Z] = (it_lo == '0);
    flags_it[F_N] = it_lo[WIDTH-1];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: accepts from IDLE and DONE are treated identically
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_iter ? ST_BUSY : ST_DONE;
      ST_BUSY: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE: begin
        if (accept)         state_d = is_iter ? ST_BUSY : ST_DONE;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    out_valid = (state_q == ST_DONE);
  end

  // Opcode capture, iteration counter and result/flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= OP_ADD;
      alu_out_q <= '0;
      flags_q   <= '0;
    end else if (accept) begin
      op_q <= alu_sel;
      if (is_iter) begin
        cnt_q <= CNT_INIT;
      end else begin
        alu_out_q <= res_sc;
        flags_q   <= flags_sc;
      end
    end else if (state_q == ST_BUSY) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (it_done) begin
        alu_out_q <= it_lo;
        flags_q   <= flags_it;
      end
    end
  end

  assign alu_out = alu_out_q;
  assign flags   = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16.
// Driver pushes expected {result, flags} per issued op; monitors pop on each output handshake.
// Directed checks cover reset, latency, backpressure hold and reset during a MUL.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        vld8, rdy8, ov8, ordy8;
  logic [7:0]  a8, b8, out8;
  logic [3:0]  sel8, fl8;
  logic        vld16, rdy16, ov16, ordy16;
  logic [15:0] a16, b16, out16;
  logic [3:0]  sel16, fl16;

  int checks = 0;
  int errors = 0;
  logic [35:0] q8[$];
  logic [35:0] q16[$];

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] fl;
  } vec_t;
  vec_t tv[20];

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld8), .in_ready(rdy8), .a(a8), .b(b8),
    .alu_sel(sel8), .out_valid(ov8), .out_ready(ordy8), .alu_out(out8), .flags(fl8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld16), .in_ready(rdy16), .a(a16), .b(b16),
    .alu_sel(sel16), .out_valid(ov16), .out_ready(ordy16), .alu_out(out16), .flags(fl16)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitors: compare every completed output handshake against the scoreboard
  always @(negedge clk) begin
    logic [35:0] e;
    if (ov8 && ordy8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected8: got result 0x%0h with nothing expected", out8);
      end else begin
        e = q8.pop_front();
        chk("res8", 32'(out8), e[35:4]);
        chk("flags8", 32'(fl8), 32'(e[3:0]));
      end
    end
  end

  always @(negedge clk) begin
    logic [35:0] e;
    if (ov16 && ordy16) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected16: got result 0x%0h with nothing expected", out16);
      end else begin
        e = q16.pop_front();
        chk("res16", 32'(out16), e[35:4]);
        chk("flags16", 32'(fl16), 32'(e[3:0]));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, record its expected response, return just after the accept edge
  task automatic send(input bit w16, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] res, input logic [3:0] fl);
    int n;
    if (w16) begin
      a16 = a; b16 = b; sel16 = op; vld16 = 1'b1;
      q16.push_back({16'b0, res, fl});
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sel8 = op; vld8 = 1'b1;
      q8.push_back({16'b0, res, fl});
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(w16 ? rdy16 : rdy8) && n < 100);
    if (!(w16 ? rdy16 : rdy8)) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", n);
    end
    sync();
    vld8  = 1'b0;
    vld16 = 1'b0;
  endtask

  task automatic drain(input bit w16);
    int n;
    n = 0;
    while ((w16 ? q16.size() : q8.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(w16 ? "drain16" : "drain8", w16 ? q16.size() : q8.size(), 0);
    sync();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv = '{
      '{OP_AND,  8'hF0, 8'h3C, 8'h30, 4'h0},
      '{OP_OR,   8'h12, 8'h21, 8'h33, 4'h0},
      '{OP_XOR,  8'hFF, 8'h0F, 8'hF0, 4'h2},
      '{OP_NOR,  8'h00, 8'h00, 8'hFF, 4'h2},
      '{OP_NAND, 8'hFF, 8'hFF, 8'h00, 4'h4},
      '{OP_XNOR, 8'hAA, 8'h55, 8'h00, 4'h4},
      '{OP_GT,   8'h05, 8'h03, 8'h01, 4'h0},
      '{OP_GT,   8'h03, 8'h05, 8'h00, 4'h4},
      '{OP_EQ,   8'h07, 8'h07, 8'h01, 4'h0},
      '{OP_EQ,   8'h07, 8'h08, 8'h00, 4'h4},
      '{OP_SHL1, 8'h81, 8'h00, 8'h02, 4'h8},
      '{OP_SHR1, 8'h81, 8'h00, 8'h40, 4'h8},
      '{OP_ROL1, 8'h81, 8'h00, 8'h03, 4'h0},
      '{OP_ROR1, 8'h81, 8'h00, 8'hC0, 4'h2},
      '{OP_SUB,  8'h05, 8'h05, 8'h00, 4'h4},
      '{OP_SUB,  8'h80, 8'h01, 8'h7F, 4'h1},
      '{OP_MUL,  8'hFF, 8'hFF, 8'h01, 4'h8},
      '{OP_MUL,  8'h03, 8'h05, 8'h0F, 4'h0},
      '{OP_DIV,  8'h07, 8'h09, 8'h00, 4'h4},
      '{OP_DIV,  8'hFF, 8'h01, 8'hFF, 4'h2}
    };
    rst_n = 1'b0;
    vld8 = 1'b0; a8 = '0; b8 = '0; sel8 = '0; ordy8 = 1'b1;
    vld16 = 1'b0; a16 = '0; b16 = '0; sel16 = '0; ordy16 = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(rdy8), 1);
    chk("rst_out_valid", 32'(ov8), 0);
    chk("rst_alu_out", 32'(out8), 0);
    chk("rst_flags", 32'(fl8), 0);
    chk("rst_out_valid16", 32'(ov16), 0);
    sync();
    rst_n = 1'b1;

    // Basic arithmetic and single-cycle latency
    send(0, OP_ADD, 16'h0A, 16'h02, 16'h0C, 4'b0000);
    @(negedge clk);
    chk("add_latency", 32'(ov8), 1);
    sync();
    send(0, OP_ADD, 16'hF6, 16'h0A, 16'h00, 4'b1100);
    send(0, OP_SUB, 16'h02, 16'h0A, 16'hF8, 4'b1010);
    send(0, OP_ADD, 16'h7F, 16'h01, 16'h80, 4'b0011);

    // MUL: 8 busy cycles, result on the 9th
    send(0, OP_MUL, 16'h10, 16'h20, 16'h00, 4'b1100);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mul_busy_in_ready", 32'(rdy8), 0);
      chk("mul_busy_out_valid", 32'(ov8), 0);
    end
    @(negedge clk);
    chk("mul_latency", 32'(ov8), 1);
    sync();

    send(0, OP_DIV, 16'hF6, 16'h0A, 16'h18, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("div_busy_in_ready", 32'(rdy8), 0);
    end
    @(negedge clk);
    chk("div_latency", 32'(ov8), 1);
    sync();

    // Divide by zero completes in one cycle
    send(0, OP_DIV, 16'h55, 16'h00, 16'hFF, 4'b0011);
    @(negedge clk);
    chk("div0_latency", 32'(ov8), 1);
    sync();

    // Remaining opcodes, issued back to back
    for (int i = 0; i < 20; i++)
      send(0, tv[i].op, {8'h00, tv[i].a}, {8'h00, tv[i].b}, {8'h00, tv[i].res}, tv[i].fl);
    drain(0);

    // Backpressure: result held, new op pending with changed operands
    ordy8 = 1'b0;
    send(0, OP_ADD, 16'h01, 16'h02, 16'h03, 4'b0000);
    a8 = 8'h0F; b8 = 8'h01; sel8 = OP_XOR; vld8 = 1'b1;
    q8.push_back({16'b0, 16'h000E, 4'b0000});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(ov8), 1);
      chk("hold_alu_out", 32'(out8), 32'h03);
      chk("hold_flags", 32'(fl8), 0);
      chk("hold_in_ready", 32'(rdy8), 0);
    end
    sync();
    ordy8 = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(rdy8), 1);
    sync();
    vld8 = 1'b0;
    @(negedge clk);
    chk("release_next_valid", 32'(ov8), 1);
    sync();
    drain(0);

    // Reset three cycles into a MUL discards it
    a8 = 8'h10; b8 = 8'h20; sel8 = OP_MUL; vld8 = 1'b1;
    @(negedge clk);
    chk("rstmul_accept", 32'(rdy8), 1);
    sync();
    vld8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmul_out_valid", 32'(ov8), 0);
    chk("rstmul_in_ready", 32'(rdy8), 1);
    chk("rstmul_alu_out", 32'(out8), 0);
    chk("rstmul_flags", 32'(fl8), 0);
    sync();
    send(0, OP_ADD, 16'h0A, 16'h02, 16'h0C, 4'b0000);
    drain(0);

    // WIDTH=16
    send(1, OP_ADD, 16'h1234, 16'h1111, 16'h2345, 4'b0000);
    send(1, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100);
    send(1, OP_SUB, 16'h0002, 16'h000A, 16'hFFF8, 4'b1010);
    send(1, OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011);
    send(1, OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b1100);
    send(1, OP_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 4'b0010);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("mul16_busy_in_ready", 32'(rdy16), 0);
    end
    @(negedge clk);
    chk("mul16_latency", 32'(ov16), 1);
    sync();
    send(1, OP_DIV, 16'hFFFF, 16'h0010, 16'h0FFF, 4'b0000);
    drain(1);
    drain(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Adds a valid/ready handshake on input and output, a registered 4-bit flag vector, and iterative multi-cycle multiply and divide.
- Sits between an operand source (register file or bench driver) and a result consumer; one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values 4..32.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and opcode are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- alu_sel  input  4  opcode.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- alu_out  output  WIDTH  result.
- flags  output  4  {C, Z, N, V}.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV.
  - 4 SHL1, 5 SHR1, 6 ROL1, 7 ROR1 (all by one bit).
  - 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR.
  - E GT: result 1 if a>b unsigned, else 0.
  - F EQ: result 1 if a==b, else 0.
- Arithmetic is unsigned and the result is truncated to WIDTH.
- C flag:
  - ADD: carry out of bit WIDTH-1.
  - SUB: borrow (a<b).
  - MUL: OR of the high WIDTH product bits.
  - SHL1: shifted-out msb. SHR1: shifted-out lsb.
  - All other opcodes: 0.
- V flag:
  - ADD/SUB: two's-complement signed overflow.
  - DIV: divide-by-zero.
  - All other opcodes: 0.
- Z = (alu_out==0) and N = alu_out[WIDTH-1], for every opcode.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On accept (in_valid&&in_ready), a, b and alu_sel are captured. Single-cycle ops write alu_out/flags at that edge and go to DONE. MUL/DIV load the iterator, set cnt=WIDTH, and go to BUSY.
  - BUSY: one iteration per cycle, cnt decrements. When cnt==1, write the result and go to DONE. in_ready=0. in_valid is ignored.
  - DONE: out_valid=1.
    - out_ready=1 with no new accept: go to IDLE.
    - in_ready = out_ready in DONE, so back-to-back ops are allowed. On simultaneous output handshake and input accept, behave exactly as an accept from IDLE.
    - out_ready=0: alu_out, flags and out_valid are held stable.
- Latency, accept edge to first cycle with out_valid=1:
  - Single-cycle ops: 1 cycle.
  - MUL/DIV: WIDTH+1 cycles.
- Throughput for single-cycle ops with out_ready held 1: one result per cycle.
- MUL is shift-add, lsb-first over WIDTH iterations. DIV is restoring, msb-first over WIDTH iterations; it produces the quotient only.
- DIV with b==0: no iteration. alu_out is all-ones, V=1, C=0. Result is in DONE after 1 cycle.
- Reset, in any state including mid-BUSY: state=IDLE, in_ready=1, out_valid=0, alu_out=0, flags=0, cnt=0, iterator registers=0. Any partial MUL/DIV is discarded.
- Inputs are sampled only at the accept edge. Changing a, b or alu_sel during BUSY or DONE has no effect.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_ADD..OP_EQ;
  - state encoding ST_IDLE, ST_BUSY, ST_DONE;
  - flag bit indices F_C=3, F_Z=2, F_N=1, F_V=0.
- Sub-module alu_muldiv_iter (one instance) contains the shift-add/restoring datapath.
  - Inputs: start, is_div, a, b, step.
  - Outputs: lo, hi, plus a done pulse on the final iteration.
  - The parent owns the FSM, counter, single-cycle datapath and flag generation.

Test Plan (WIDTH=8 unless stated):
- ADD a=0x0A, b=0x02, out_ready=1 -> next cycle out_valid=1, alu_out=0x0C, flags=0000. Then ADD a=0xF6, b=0x0A -> alu_out=0x00, C=1, Z=1.
- SUB a=0x02, b=0x0A -> alu_out=0xF8, C=1, N=1, V=0. ADD a=0x7F, b=0x01 -> alu_out=0x80, N=1, V=1.
- MUL a=0x10, b=0x20 -> in_ready=0 for 8 cycles; out_valid on the 9th cycle; alu_out=0x00, C=1, Z=1. DIV a=0xF6, b=0x0A -> alu_out=0x18 after 9 cycles.
- DIV a=0x55, b=0x00 -> 1 cycle later alu_out=0xFF, V=1, N=1.
- Backpressure: out_ready=0 for 5 cycles after a result -> alu_out, flags and out_valid stable; in_ready=0. Raising out_ready with in_valid=1 accepts the next op in the same cycle.
- Assert rst_n=0 for one cycle 3 cycles into a MUL -> next cycle out_valid=0, in_ready=1, alu_out=0. A fresh ADD then completes normally. Repeat the ADD/MUL cases with WIDTH=16, including MUL 0x0100*0x0100 -> alu_out=0x0000, C=1.
